// File: rtl/mdr_control.sv
// Sequencer for the multiply/divide/root datapath: captures X/Y from the shared bus,
// pulses the selected unit's start, waits for its ready (bounded), and latches the result.
// Operation encoding on i_op/o_sel: 0=NON, 1=MULT, 2=DIV, 3=ROOT.
module mdr_control #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_result,
  input  logic [DW-1:0] i_remainder,
  input  logic          i_ready,
  output logic [1:0]    o_sel,
  output logic [DW-1:0] o_op_x,
  output logic [DW-1:0] o_op_y,
  output logic          o_start_mult,
  output logic          o_start_div,
  output logic          o_start_root,
  output logic [DW-1:0] o_result,
  output logic [DW-1:0] o_remainder,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);
  localparam logic [1:0] OP_NON  = 2'd0;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_ROOT = 2'd3;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT - 1);
  // Leaving BUSY on this count makes ERROR land exactly TIMEOUT cycles after START.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_Y, S_START, S_BUSY, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    op;
  logic [TW-1:0] timer;
  logic          idle_like, accept;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign accept    = idle_like && i_start && (i_op != OP_NON);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (accept) state_nxt = S_LOAD_X;
      S_LOAD_X:
        if (i_load) state_nxt = (op == OP_ROOT) ? S_START : S_LOAD_Y;
      S_LOAD_Y:
        if (i_load) state_nxt = (op == OP_DIV && i_data == '0) ? S_ERROR : S_START;
      S_START:
        state_nxt = S_BUSY;
      S_BUSY:
        if (i_ready)              state_nxt = S_DONE;
        else if (timer == T_LAST) state_nxt = S_ERROR;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op          <= OP_NON;
      o_op_x      <= '0;
      o_op_y      <= '0;
      o_result    <= '0;
      o_remainder <= '0;
      timer       <= '0;
    end else begin
      if (accept) begin
        op          <= i_op;
        o_op_x      <= '0;
        o_op_y      <= '0;
        o_result    <= '0;
        o_remainder <= '0;
      end
      if (state == S_LOAD_X && i_load) o_op_x <= i_data;
      if (state == S_LOAD_Y && i_load) o_op_y <= i_data;
      if (state == S_START) timer <= '0;
      if (state == S_BUSY) begin
        if (i_ready) begin
          o_result    <= i_result;
          o_remainder <= (op == OP_MULT) ? '0 : i_remainder;
        end else if (timer != T_MAX) begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_sel        = OP_NON;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_start_mult = 1'b0;
    o_start_div  = 1'b0;
    o_start_root = 1'b0;
    case (state)
      S_LOAD_X, S_LOAD_Y, S_BUSY: begin
        o_sel  = op;
        o_busy = 1'b1;
      end
      S_START: begin
        o_sel        = op;
        o_busy       = 1'b1;
        o_start_mult = (op == OP_MULT);
        o_start_div  = (op == OP_DIV);
        o_start_root = (op == OP_ROOT);
      end
      S_DONE: begin
        o_sel  = op;
        o_done = 1'b1;
      end
      S_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mdr_control.sv
// Directed bench for mdr_control: a negedge-driven unit model returns ready after
// a programmable latency; each scenario task checks its own expectations inline.
module tb_mdr_control;
  localparam int DW = 16;
  localparam int TIMEOUT = 64;
  localparam logic [1:0] NON = 2'd0, MULT = 2'd1, DIV = 2'd2, ROOT = 2'd3;

  logic clk = 0, rst = 0;
  logic i_start = 0, i_load = 0, i_ready = 0;
  logic [1:0] i_op = NON;
  logic [DW-1:0] i_data = 0, i_result = 0, i_remainder = 0;
  logic [1:0] o_sel;
  logic [DW-1:0] o_op_x, o_op_y, o_result, o_remainder;
  logic o_start_mult, o_start_div, o_start_root, o_busy, o_done, o_error;

  int checks = 0, errors = 0;
  int unit_lat = 3, cnt = 0, n_starts = 0;
  bit unit_en = 1;

  mdr_control #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_load(i_load),
    .i_data(i_data), .i_result(i_result), .i_remainder(i_remainder), .i_ready(i_ready),
    .o_sel(o_sel), .o_op_x(o_op_x), .o_op_y(o_op_y), .o_start_mult(o_start_mult),
    .o_start_div(o_start_div), .o_start_root(o_start_root), .o_result(o_result),
    .o_remainder(o_remainder), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Unit model: ready is high for one cycle, unit_lat cycles after the start pulse.
  always @(negedge clk) begin
    i_ready = 0;
    if (!rst) cnt = 0;
    else if (o_start_mult | o_start_div | o_start_root) begin
      n_starts++;
      cnt = unit_lat;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && unit_en) i_ready = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; tick(); rst = 1; n_starts = 0; unit_en = 1;
  endtask

  task automatic do_start(input logic [1:0] op);
    i_start = 1; i_op = op; tick(); i_start = 0; i_op = NON;
  endtask

  task automatic do_load(input logic [DW-1:0] d);
    i_load = 1; i_data = d; tick(); i_load = 0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(o_done | o_error) && n < 200) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 0; #2;
    checks++;
    if ({o_sel, o_busy, o_done, o_error, o_start_mult, o_start_div, o_start_root} !== '0 ||
        {o_op_x, o_op_y, o_result, o_remainder} !== '0) begin
      errors++; $display("FAIL reset: sel=%0d busy=%b done=%b err=%b x=%0d res=%0d, want all 0",
                         o_sel, o_busy, o_done, o_error, o_op_x, o_result);
    end
    tick(); rst = 1;
  endtask

  task automatic test_mult();
    int n;
    do_reset(); unit_lat = 3; i_result = 42; i_remainder = 99;
    do_start(MULT);
    checks++;
    if (o_busy !== 1 || o_sel !== MULT) begin
      errors++; $display("FAIL mult_loadx: busy=%b sel=%0d want 1/%0d", o_busy, o_sel, MULT);
    end
    do_load(7); do_load(6);
    checks++;
    if (o_start_mult !== 1 || o_start_div !== 0 || o_op_x !== 7 || o_op_y !== 6) begin
      errors++; $display("FAIL mult_start: sm=%b sd=%b x=%0d y=%0d want 1 0 7 6",
                         o_start_mult, o_start_div, o_op_x, o_op_y);
    end
    wait_end(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL mult_latency: got %0d edges want 4", n); end
    checks++;
    if (o_done !== 1 || o_busy !== 0 || o_result !== 42 || o_remainder !== 0 ||
        o_sel !== MULT || n_starts !== 1) begin
      errors++; $display("FAIL mult_result: done=%b busy=%b res=%0d rem=%0d sel=%0d starts=%0d want 1 0 42 0 1 1",
                         o_done, o_busy, o_result, o_remainder, o_sel, n_starts);
    end
  endtask

  task automatic test_div();
    int n;
    do_reset(); unit_lat = 2; i_result = 3; i_remainder = 2;
    do_start(DIV); do_load(17); do_load(5);
    checks++;
    if (o_start_div !== 1 || o_start_mult !== 0 || o_start_root !== 0) begin
      errors++; $display("FAIL div_start: sm=%b sd=%b sr=%b want 0 1 0",
                         o_start_mult, o_start_div, o_start_root);
    end
    wait_end(n);
    checks++;
    if (n !== 3 || o_done !== 1 || o_result !== 3 || o_remainder !== 2) begin
      errors++; $display("FAIL div_result: n=%0d done=%b res=%0d rem=%0d want 3 1 3 2",
                         n, o_done, o_result, o_remainder);
    end
    i_result = 77; i_remainder = 11;
    repeat (4) tick();
    checks++;
    if (o_done !== 1 || o_result !== 3 || o_remainder !== 2 || n_starts !== 1) begin
      errors++; $display("FAIL div_hold: done=%b res=%0d rem=%0d starts=%0d want 1 3 2 1",
                         o_done, o_result, o_remainder, n_starts);
    end
    do_start(MULT);
    checks++;
    if (o_busy !== 1 || o_result !== 0 || o_remainder !== 0 || o_op_x !== 0 || o_op_y !== 0) begin
      errors++; $display("FAIL div_restart_clear: busy=%b res=%0d rem=%0d x=%0d y=%0d want 1 0 0 0 0",
                         o_busy, o_result, o_remainder, o_op_x, o_op_y);
    end
  endtask

  task automatic test_div_zero();
    do_reset(); unit_lat = 2;
    do_start(DIV); do_load(9); do_load(0);
    checks++;
    if (o_error !== 1 || o_sel !== NON || o_busy !== 0 || o_start_div !== 0) begin
      errors++; $display("FAIL div0: err=%b sel=%0d busy=%b sd=%b want 1 0 0 0",
                         o_error, o_sel, o_busy, o_start_div);
    end
    repeat (3) tick();
    checks++;
    if (n_starts !== 0 || o_error !== 1) begin
      errors++; $display("FAIL div0_nostart: starts=%0d err=%b want 0 1", n_starts, o_error);
    end
  endtask

  task automatic test_root();
    int n;
    do_reset(); unit_lat = 4; i_result = 5; i_remainder = 1;
    do_start(ROOT); do_load(26);
    checks++;
    if (o_start_root !== 1 || o_op_x !== 26 || o_op_y !== 0 || o_sel !== ROOT) begin
      errors++; $display("FAIL root_start: sr=%b x=%0d y=%0d sel=%0d want 1 26 0 3",
                         o_start_root, o_op_x, o_op_y, o_sel);
    end
    wait_end(n);
    checks++;
    if (n !== 5 || o_done !== 1 || o_result !== 5 || o_remainder !== 1) begin
      errors++; $display("FAIL root_result: n=%0d done=%b res=%0d rem=%0d want 5 1 5 1",
                         n, o_done, o_result, o_remainder);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset(); unit_en = 0; unit_lat = 3;
    do_start(MULT); do_load(3); do_load(4);
    wait_end(n);
    checks++;
    if (n !== TIMEOUT || o_error !== 1 || o_done !== 0 || o_sel !== NON) begin
      errors++; $display("FAIL timeout: n=%0d err=%b done=%b sel=%0d want %0d 1 0 0",
                         n, o_error, o_done, o_sel, TIMEOUT);
    end
    do_start(NON);
    checks++;
    if (o_error !== 1 || o_busy !== 0) begin
      errors++; $display("FAIL start_non: err=%b busy=%b want 1 0", o_error, o_busy);
    end
    do_start(DIV);
    checks++;
    if (o_busy !== 1 || o_error !== 0 || o_sel !== DIV) begin
      errors++; $display("FAIL restart_div: busy=%b err=%b sel=%0d want 1 0 2", o_busy, o_error, o_sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); unit_lat = 20; i_result = 9;
    do_start(MULT); do_load(12); do_load(13); tick(); tick();
    rst = 0; #2;
    checks++;
    if (o_busy !== 0 || o_sel !== NON || o_op_x !== 0 || o_op_y !== 0 ||
        o_start_mult !== 0 || o_done !== 0 || o_error !== 0) begin
      errors++; $display("FAIL reset_mid: busy=%b sel=%0d x=%0d y=%0d sm=%b want all 0",
                         o_busy, o_sel, o_op_x, o_op_y, o_start_mult);
    end
    tick(); rst = 1;
    i_start = 1; i_op = MULT; i_load = 1; i_data = 55; tick();
    i_start = 0; i_op = NON; i_load = 0;
    checks++;
    if (o_busy !== 1 || o_op_x !== 0) begin
      errors++; $display("FAIL start_load_same: busy=%b x=%0d want 1 0", o_busy, o_op_x);
    end
    do_load(8);
    checks++;
    if (o_op_x !== 8 || o_busy !== 1) begin
      errors++; $display("FAIL load_after: x=%0d busy=%b want 8 1", o_op_x, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_root();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
